// File: rtl/keyboard_move_decoder_if.sv
// Scan-byte input and decoded direction/keycode outputs of keyboard_move_decoder.
// The master side feeds scan bytes; the slave side is the decoder.
interface keyboard_move_decoder_if;
  logic [7:0]  scan_byte;
  logic        scan_valid;
  logic        move_up;
  logic        move_down;
  logic        move_right;
  logic        move_left;
  logic [15:0] keycode;
  logic        keycode_valid;

  modport master (
    output scan_byte, scan_valid,
    input  move_up, move_down, move_right, move_left, keycode, keycode_valid
  );

  modport slave (
    input  scan_byte, scan_valid,
    output move_up, move_down, move_right, move_left, keycode, keycode_valid
  );
endinterface

// File: rtl/keyboard_move_decoder.sv
// PS/2 set-2 scan bytes -> held direction flags and last make code; outputs 1 clk after the final byte, no backpressure.
// Define KBD_WASD_EN to also map W/S/D/A onto up/down/right/left.
module keyboard_move_decoder #(
  parameter int TIMEOUT_CYCLES  = 400_000,
  parameter bit CANCEL_OPPOSING = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  keyboard_move_decoder_if.slave kbd
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [CNT_W-1:0] tmo_cnt;
  logic        tmo_hit;
  logic        is_ctrl;
  logic        make_evt;
  logic        brk_evt;
  logic [15:0] evt_code;

  logic [3:0]  arrow_held;
  logic [3:0]  arrow_nxt;
  logic [3:0]  dir_raw;
  logic [3:0]  move_q;
  logic [15:0] keycode_q;
  logic        keycode_vld;

  // Direction vectors use bit 0 = up, 1 = down, 2 = right, 3 = left.
  function automatic logic [3:0] arrow_map(input logic [15:0] code);
    case (code)
      16'hE075: arrow_map = 4'b0001;
      16'hE072: arrow_map = 4'b0010;
      16'hE074: arrow_map = 4'b0100;
      16'hE06B: arrow_map = 4'b1000;
      default:  arrow_map = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] resolve(input logic [3:0] d);
    resolve = d;
    if (CANCEL_OPPOSING) begin
      if (d[0] && d[1]) resolve[1:0] = 2'b00;
      if (d[2] && d[3]) resolve[3:2] = 2'b00;
    end
  endfunction

  assign is_ctrl = kbd.scan_byte inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
  // A byte arriving on the expiry cycle still belongs to the pending prefix.
  assign tmo_hit = (state != IDLE) && !kbd.scan_valid && (tmo_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (kbd.scan_valid || state == IDLE || tmo_hit) tmo_cnt <= '0;
      else                                             tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (kbd.scan_valid) begin
      case (state)
        IDLE: begin
          if (kbd.scan_byte == 8'hE0)      state_nxt = EXT;
          else if (kbd.scan_byte == 8'hF0) state_nxt = BRK;
        end
        EXT: begin
          if (kbd.scan_byte == 8'hF0)      state_nxt = EXT_BRK;
          else if (kbd.scan_byte != 8'hE0) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit) begin
      state_nxt = IDLE;
    end
  end

  always_comb begin
    make_evt = 1'b0;
    brk_evt  = 1'b0;
    evt_code = 16'h0000;
    if (kbd.scan_valid) begin
      case (state)
        IDLE: begin
          if (kbd.scan_byte != 8'hE0 && kbd.scan_byte != 8'hF0 && !is_ctrl) begin
            make_evt = 1'b1;
            evt_code = {8'h00, kbd.scan_byte};
          end
        end
        EXT: begin
          if (kbd.scan_byte != 8'hE0 && kbd.scan_byte != 8'hF0) begin
            make_evt = 1'b1;
            evt_code = {8'hE0, kbd.scan_byte};
          end
        end
        BRK: begin
          brk_evt  = 1'b1;
          evt_code = {8'h00, kbd.scan_byte};
        end
        default: begin
          brk_evt  = 1'b1;
          evt_code = {8'hE0, kbd.scan_byte};
        end
      endcase
    end
  end

  always_comb begin
    arrow_nxt = arrow_held;
    if (make_evt)     arrow_nxt = arrow_held | arrow_map(evt_code);
    else if (brk_evt) arrow_nxt = arrow_held & ~arrow_map(evt_code);
  end

`ifdef KBD_WASD_EN
  logic [3:0] wasd_held;
  logic [3:0] wasd_nxt;

  function automatic logic [3:0] wasd_map(input logic [15:0] code);
    case (code)
      16'h001D: wasd_map = 4'b0001;
      16'h001B: wasd_map = 4'b0010;
      16'h0023: wasd_map = 4'b0100;
      16'h001C: wasd_map = 4'b1000;
      default:  wasd_map = 4'b0000;
    endcase
  endfunction

  always_comb begin
    wasd_nxt = wasd_held;
    if (make_evt)     wasd_nxt = wasd_held | wasd_map(evt_code);
    else if (brk_evt) wasd_nxt = wasd_held & ~wasd_map(evt_code);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wasd_held <= 4'b0000;
    else      wasd_held <= wasd_nxt;
  end

  assign dir_raw = arrow_nxt | wasd_nxt;
`else
  assign dir_raw = arrow_nxt;
`endif

  // Outputs register the next held state so moves track the final byte by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arrow_held  <= 4'b0000;
      move_q      <= 4'b0000;
      keycode_q   <= 16'h0000;
      keycode_vld <= 1'b0;
    end else begin
      arrow_held  <= arrow_nxt;
      move_q      <= resolve(dir_raw);
      keycode_vld <= make_evt;
      if (make_evt)                              keycode_q <= evt_code;
      else if (brk_evt && evt_code == keycode_q) keycode_q <= 16'h0000;
    end
  end

  assign kbd.move_up       = move_q[0];
  assign kbd.move_down     = move_q[1];
  assign kbd.move_right    = move_q[2];
  assign kbd.move_left     = move_q[3];
  assign kbd.keycode       = keycode_q;
  assign kbd.keycode_valid = keycode_vld;

endmodule

// File: tb/tb_keyboard_move_decoder.sv
// Directed-vector bench for keyboard_move_decoder with a 16-cycle prefix timeout.
`timescale 1ns/1ps
module tb_keyboard_move_decoder;
  localparam logic [15:0] UP = 16'h8, DOWN = 16'h4, RIGHT = 16'h2, LEFT = 16'h1, NONE = 16'h0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   kv_count = 0;
  int   kv_base;

  keyboard_move_decoder_if kbd ();

  keyboard_move_decoder #(.TIMEOUT_CYCLES(16), .CANCEL_OPPOSING(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .kbd (kbd)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst && kbd.keycode_valid) kv_count++;

  // Moves packed as {up, down, right, left}.
  function automatic logic [15:0] moves();
    return {12'd0, kbd.move_up, kbd.move_down, kbd.move_right, kbd.move_left};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    kbd.scan_byte  = b;
    kbd.scan_valid = 1'b1;
    @(negedge clk);
    kbd.scan_valid = 1'b0;
  endtask

  initial begin
    kbd.scan_byte  = 8'h00;
    kbd.scan_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_moves", moves(), NONE);
    check("reset_keycode", kbd.keycode, 16'h0000);
    check("reset_kv", {15'd0, kbd.keycode_valid}, 16'h0);
    rst = 1'b1;

    // Extended make/break of the up arrow
    kv_base = kv_count;
    send(8'hE0);
    check("up_after_prefix", moves(), NONE);
    send(8'h75);
    check("up_make_moves", moves(), UP);
    check("up_make_keycode", kbd.keycode, 16'hE075);
    check("up_make_kv", {15'd0, kbd.keycode_valid}, 16'h1);
    @(negedge clk);
    check("up_make_kv_once", 16'(kv_count - kv_base), 16'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("up_break_moves", moves(), NONE);
    check("up_break_keycode", kbd.keycode, 16'h0000);
    check("up_break_kv", {15'd0, kbd.keycode_valid}, 16'h0);

    // Letter A
    send(8'h1C);
    check("a_make_keycode", kbd.keycode, 16'h001C);
    check("a_make_kv", {15'd0, kbd.keycode_valid}, 16'h1);
`ifdef KBD_WASD_EN
    check("a_make_moves", moves(), LEFT);
`else
    check("a_make_moves", moves(), NONE);
`endif
    send(8'hF0); send(8'h1C);
    check("a_break_keycode", kbd.keycode, 16'h0000);
    check("a_break_moves", moves(), NONE);

    // Opposing directions on the vertical axis
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'h72);
    check("ud_cancel", moves(), NONE);
    check("ud_keycode", kbd.keycode, 16'hE072);
    send(8'hE0); send(8'hF0); send(8'h72);
    check("ud_release_down", moves(), UP);
    check("ud_release_down_kc", kbd.keycode, 16'h0000);
    send(8'hE0); send(8'h72);
    check("ud_cancel_again", moves(), NONE);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("ud_release_up", moves(), DOWN);
    check("ud_nonmatch_break_kc", kbd.keycode, 16'hE072);
    send(8'hE0); send(8'hF0); send(8'h72);
    check("ud_all_released", moves(), NONE);

    // Horizontal cancel does not affect the vertical axis
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    send(8'hE0); send(8'h75);
    check("lr_cancel_up_kept", moves(), UP);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("lr_right_only", moves(), RIGHT);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("lr_all_released", moves(), NONE);

    // Prefix still pending after a short gap
    send(8'hE0);
    repeat (10) @(negedge clk);
    send(8'h74);
    check("short_gap_keycode", kbd.keycode, 16'hE074);
    check("short_gap_moves", moves(), RIGHT);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("short_gap_release", moves(), NONE);

    // Prefix dropped after the timeout
    send(8'hE0);
    repeat (20) @(negedge clk);
    send(8'h74);
    check("timeout_keycode", kbd.keycode, 16'h0074);
    check("timeout_moves", moves(), NONE);
    send(8'hF0); send(8'h74);
    check("timeout_release_kc", kbd.keycode, 16'h0000);

    // Control bytes are ignored in IDLE
    send(8'h16);
    send(8'hAA);
    check("ctrl_aa_kv", {15'd0, kbd.keycode_valid}, 16'h0);
    send(8'hFA);
    send(8'h00);
    check("ctrl_keycode_kept", kbd.keycode, 16'h0016);
    send(8'hF0); send(8'h16);
    check("ctrl_release_kc", kbd.keycode, 16'h0000);

    // Back-to-back strobes
    @(negedge clk);
    kbd.scan_byte  = 8'hE0;
    kbd.scan_valid = 1'b1;
    @(negedge clk);
    kbd.scan_byte  = 8'h75;
    @(negedge clk);
    kbd.scan_valid = 1'b0;
    check("b2b_moves", moves(), UP);
    check("b2b_keycode", kbd.keycode, 16'hE075);
    send(8'hE0); send(8'hF0); send(8'h75);

    // Typematic repeats, then reset mid-break
    kv_base = kv_count;
    for (int i = 0; i < 3; i++) begin
      send(8'hE0); send(8'h6B);
      check("typematic_left", moves(), LEFT);
    end
    @(negedge clk);
    check("typematic_kv_count", 16'(kv_count - kv_base), 16'd3);
    check("typematic_keycode", kbd.keycode, 16'hE06B);
    send(8'hE0); send(8'hF0);
    check("pre_reset_left", moves(), LEFT);
    #2 rst = 1'b0;
    #1;
    check("mid_reset_moves", moves(), NONE);
    check("mid_reset_keycode", kbd.keycode, 16'h0000);
    check("mid_reset_kv", {15'd0, kbd.keycode_valid}, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    send(8'h6B);
    check("post_reset_keycode", kbd.keycode, 16'h006B);
    check("post_reset_moves", moves(), NONE);
    check("post_reset_kv", {15'd0, kbd.keycode_valid}, 16'h1);

`ifdef KBD_WASD_EN
    send(8'hF0); send(8'h6B);
    send(8'h1D);
    check("wasd_w_up", moves(), UP);
    send(8'hE0); send(8'h75);
    send(8'hF0); send(8'h1D);
    check("wasd_arrow_keeps_up", moves(), UP);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("wasd_all_released", moves(), NONE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/keyboard_move_decoder.md
Name: keyboard_move_decoder

Overview:
- Sits directly upstream of the VGA top level.
- Consumes PS/2 scan-code bytes from the PS/2 receiver: one byte per single-cycle strobe, scan code set 2.
- Produces the level-held direction controls move_up/move_down/move_right/move_left and the 16-bit keycode that drive screen selection and screen control.
- Tracks make/break/extended prefixes with a state machine, keeps per-key held state, and discards stale prefixes with a timeout.

Parameters:
- TIMEOUT_CYCLES, 400_000: cycles a pending prefix (E0/F0) may wait for its next byte before the FSM drops it (10 ms at 40 MHz).
- CANCEL_OPPOSING, 1: 1 = opposing held directions cancel to 0; 0 = both asserted.

Ports:
- clk  in  1  system clock, same domain as the VGA pipeline
- rst  in  1  asynchronous, active-low reset
- scan_byte  in  8  received scan-code byte
- scan_valid  in  1  one-cycle strobe, scan_byte valid
- move_up  out  1  up key currently held
- move_down  out  1  down key currently held
- move_right  out  1  right key currently held
- move_left  out  1  left key currently held
- keycode  out  16  last make code: {prefix, code}, prefix = 8'hE0 for extended keys, else 8'h00
- keycode_valid  out  1  one-cycle pulse when keycode is updated

Behaviour:
- Reset (rst low, asynchronous): FSM in IDLE, all held flags 0, all move_* 0, keycode 16'h0000, keycode_valid 0, timeout counter 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). State advances only on cycles with scan_valid=1.
- IDLE transitions:
  - E0 -> EXT.
  - F0 -> BRK.
  - AA, FA, FE, EE, 00, FF (BAT/ack/resend/echo/error) -> ignored, stay IDLE.
  - Any other byte -> make of {00,byte}, stay IDLE.
- EXT transitions:
  - F0 -> EXT_BRK.
  - E0 -> stay EXT (duplicate prefix).
  - Other -> make of {E0,byte}, go IDLE.
- BRK transitions: any byte -> break of {00,byte}, go IDLE.
- EXT_BRK transitions: any byte -> break of {E0,byte}, go IDLE.
- Make event:
  - Registered one cycle after the strobe: keycode <= code, keycode_valid=1 for exactly that cycle.
  - Held flag of a mapped key set.
  - Typematic repeats are idempotent for held flags, but each repeat still pulses keycode_valid.
- Break event:
  - Held flag of the mapped key cleared.
  - If code equals the current keycode, keycode <= 0000 (no keycode_valid pulse); otherwise keycode unchanged.
- Key map (held flags): E075 = up, E072 = down, E074 = right, E06B = left. Unmapped codes affect keycode only.
- Outputs:
  - move_* are registered from the held flags.
  - Latency from the strobe cycle of the final byte to move_* change: 1 clk.
  - CANCEL_OPPOSING=1: up&down both held -> move_up=move_down=0; same rule for left&right. Each axis is independent.
- Timeout:
  - Counter runs while the FSM is in EXT, BRK or EXT_BRK, and clears on every scan_valid.
  - On reaching TIMEOUT_CYCLES-1, the FSM returns to IDLE and the pending prefix is discarded; held flags are unchanged.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- scan_valid held high for consecutive cycles: each cycle is treated as a new byte.
- Reset asserted mid-sequence: everything clears; the first byte after release is decoded from IDLE.

Optional Feature:
- Macro: KBD_WASD_EN.
- Defined: 001D (W) = up, 001B (S) = down, 0023 (D) = right, 001C (A) = left are also mapped, each with an independent held flag. move_* = OR of arrow and letter flags, with cancellation applied after the OR.
- Undefined: W/S/A/D are plain unmapped codes; they update keycode only.

Test Plan:
- Reset then E0,75 -> move_up=1 one clk after the 75 strobe; keycode=E075; keycode_valid pulses once. Then E0,F0,75 -> move_up=0, keycode=0000.
- 1C (A, macro off) -> keycode=001C, keycode_valid pulse, all move_* stay 0. Then F0,1C -> keycode=0000.
- Hold up (E0,75), then hold down (E0,72) -> both move_up and move_down 0 (CANCEL_OPPOSING=1). Release down -> move_up=1.
- E0, then no byte for TIMEOUT_CYCLES (bench sets TIMEOUT_CYCLES=16) -> FSM in IDLE. Then 74 -> keycode=0074, move_right stays 0.
- Typematic: E0,6B repeated 3 times -> move_left=1 throughout, 3 keycode_valid pulses. Assert rst mid-sequence after E0,F0 -> all outputs 0 immediately. Release, then 6B -> keycode=006B.
- KBD_WASD_EN defined: 1D -> move_up=1. E0,75 then F0,1D -> move_up stays 1. Then E0,F0,75 -> move_up=0.
